// File: rtl/adaptive_sof_restorer_pkg.sv
// Shared types and width helpers for the SOF restorer and its output stage.
// The constants give the widths of the default 1920x1080, 10-bit configuration.
package adaptive_sof_restorer_pkg;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        SOF    = 2'd1,
        ACTIVE = 2'd2
    } state_e;

    localparam int DEF_FRAME_RES_X = 1920;
    localparam int DEF_FRAME_RES_Y = 1080;
    localparam int DEF_PX_WIDTH    = 10;

    function automatic int round_up8(input int w);
        return ((w + 7) / 8) * 8;
    endfunction

    localparam int TDATA_WIDTH    = round_up8(DEF_PX_WIDTH);
    localparam int PX_CNT_WIDTH   = $clog2(DEF_FRAME_RES_X + 1);
    localparam int LINE_CNT_WIDTH = $clog2(DEF_FRAME_RES_Y + 1);

endpackage

// File: rtl/adaptive_sof_restorer_if.sv
// Generic AXI4-Stream bundle with master/slave views.
interface axi4_stream_if
    import adaptive_sof_restorer_pkg::*;
#(
    parameter int DATA_W = TDATA_WIDTH,
    parameter int USER_W = 1,
    parameter int ID_W   = 1,
    parameter int DEST_W = 1
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_W-1:0]     tdata;
    logic [DATA_W/8-1:0]   tstrb;
    logic [DATA_W/8-1:0]   tkeep;
    logic                  tlast;
    logic [USER_W-1:0]     tuser;
    logic [ID_W-1:0]       tid;
    logic [DEST_W-1:0]     tdest;

    modport master (output tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest,
                    input  tready);
    modport slave  (input  tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest,
                    output tready);
endinterface

// File: rtl/adaptive_sof_restorer_skid.sv
// Two-entry AXI4-Stream register slice: one output register plus one skid
// register, so the upstream ready is a pure flop and throughput stays at 1/cycle.
module video_skid_buffer
    import adaptive_sof_restorer_pkg::*;
#(
    parameter int DATA_W = TDATA_WIDTH,
    parameter int USER_W = 1,
    parameter int ID_W   = 1,
    parameter int DEST_W = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    axi4_stream_if.slave  s_axis,
    axi4_stream_if.master m_axis
);
    localparam int PAY_W = DATA_W + 2 * (DATA_W / 8) + 1 + USER_W + ID_W + DEST_W;

    logic [PAY_W-1:0] s_pay_s;
    logic [PAY_W-1:0] out_d, out_q, skid_d, skid_q;
    logic             out_vld_d, out_vld_q, skid_vld_d, skid_vld_q;
    logic             s_fire_s;

    assign s_pay_s = {s_axis.tdata, s_axis.tstrb, s_axis.tkeep, s_axis.tlast,
                      s_axis.tuser, s_axis.tid, s_axis.tdest};
    assign s_axis.tready = ~skid_vld_q;
    assign s_fire_s      = s_axis.tvalid & ~skid_vld_q;
    assign m_axis.tvalid = out_vld_q;
    assign {m_axis.tdata, m_axis.tstrb, m_axis.tkeep, m_axis.tlast,
            m_axis.tuser, m_axis.tid, m_axis.tdest} = out_q;

    // Next-state of the output and skid registers.
    always_comb begin
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (!out_vld_q || m_axis.tready) begin
            if (skid_vld_q) begin
                out_d      = skid_q;
                out_vld_d  = 1'b1;
                skid_vld_d = 1'b0;
            end else begin
                out_d     = s_pay_s;
                out_vld_d = s_fire_s;
            end
        end else begin
            // Output is stalled: a beat accepted this cycle parks in the skid slot.
            if (s_fire_s) begin
                skid_d     = s_pay_s;
                skid_vld_d = 1'b1;
            end else begin
                skid_vld_d = skid_vld_q;
            end
        end
    end

    // Register slice state with synchronous flush.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q      <= {PAY_W{1'b0}};
            out_vld_q  <= 1'b0;
            skid_q     <= {PAY_W{1'b0}};
            skid_vld_q <= 1'b0;
        end else begin
            out_q      <= out_d;
            out_vld_q  <= out_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
        end
    end
endmodule

// File: rtl/adaptive_sof_restorer.sv
// Restores tuser start-of-frame on a stream that marks frame ends with eof_i,
// checks line length and reports the height of each completed frame.
module adaptive_sof_restorer
    import adaptive_sof_restorer_pkg::*;
#(
    parameter int FRAME_RES_X = 1920,
    parameter int FRAME_RES_Y = 1080,
    parameter int PX_WIDTH    = 10
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    axi4_stream_if.slave                       video_i,
    input  logic                               eof_i,
    axi4_stream_if.master                      video_o,
    output logic [$clog2(FRAME_RES_Y+1)-1:0]   lines_per_frame_o,
    output logic                               frame_done_o,
    output logic                               line_len_err_o
);
    localparam int TDATA_W = round_up8(PX_WIDTH);
    localparam int PXW     = $clog2(FRAME_RES_X + 1);
    localparam int LCW     = $clog2(FRAME_RES_Y + 1);
    localparam logic [PXW:0]   RES_X_EXT = (PXW + 1)'(FRAME_RES_X);
    localparam logic [LCW-1:0] RES_Y     = LCW'(FRAME_RES_Y);

    state_e           state_d, state_q;
    logic [PXW-1:0]   px_cnt_d, px_cnt_q;
    logic [LCW-1:0]   line_cnt_d, line_cnt_q, lines_per_frame_d, lines_per_frame_q;
    logic [LCW-1:0]   line_sat_s;
    logic             frame_done_d, frame_done_q, line_len_err_d, line_len_err_q;
    logic             fire_s, eol_s, eof_s;

    axi4_stream_if #(.DATA_W(TDATA_W)) mid_axis ();

    // SYNC swallows beats so a frame cut by reset never reaches the output.
    assign video_i.tready = (state_q == SYNC) ? 1'b1 : mid_axis.tready;
    assign fire_s = video_i.tvalid & video_i.tready;
    assign eol_s  = fire_s & video_i.tlast;
    assign eof_s  = eol_s & eof_i;

    assign mid_axis.tvalid = video_i.tvalid & (state_q != SYNC);
    assign mid_axis.tdata  = video_i.tdata;
    assign mid_axis.tstrb  = video_i.tstrb;
    assign mid_axis.tkeep  = video_i.tkeep;
    assign mid_axis.tlast  = video_i.tlast;
    assign mid_axis.tid    = video_i.tid;
    assign mid_axis.tdest  = video_i.tdest;
    assign mid_axis.tuser  = (state_q == SOF);

    video_skid_buffer #(.DATA_W(TDATA_W)) u_skid (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .s_axis (mid_axis),
        .m_axis (video_o)
    );

    assign line_sat_s = (line_cnt_q == RES_Y) ? RES_Y : line_cnt_q + LCW'(1);

    // Frame-position FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SYNC:    if (eof_s) state_d = SOF; else state_d = SYNC;
            SOF:     if (eof_s) state_d = SOF; else if (fire_s) state_d = ACTIVE; else state_d = SOF;
            ACTIVE:  if (eof_s) state_d = SOF; else state_d = ACTIVE;
            default: state_d = SYNC;
        endcase
    end

    // Pixel/line counters and status pulses; lines_per_frame only reports synced frames.
    always_comb begin
        px_cnt_d          = px_cnt_q;
        line_cnt_d        = line_cnt_q;
        lines_per_frame_d = lines_per_frame_q;
        frame_done_d      = 1'b0;
        line_len_err_d    = 1'b0;
        if (eol_s) begin
            px_cnt_d       = {PXW{1'b0}};
            line_len_err_d = (({1'b0, px_cnt_q} + (PXW + 1)'(1)) != RES_X_EXT);
            frame_done_d   = eof_i;
            if (state_q == SYNC) begin
                line_cnt_d = {LCW{1'b0}};
            end else if (eof_i) begin
                lines_per_frame_d = line_sat_s;
                line_cnt_d        = {LCW{1'b0}};
            end else begin
                line_cnt_d = line_sat_s;
            end
        end else if (fire_s) begin
            px_cnt_d = (px_cnt_q == {PXW{1'b1}}) ? px_cnt_q : px_cnt_q + PXW'(1);
        end else begin
            px_cnt_d = px_cnt_q;
        end
    end

    // State, counter and status registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q           <= SYNC;
            px_cnt_q          <= {PXW{1'b0}};
            line_cnt_q        <= {LCW{1'b0}};
            lines_per_frame_q <= {LCW{1'b0}};
            frame_done_q      <= 1'b0;
            line_len_err_q    <= 1'b0;
        end else begin
            state_q           <= state_d;
            px_cnt_q          <= px_cnt_d;
            line_cnt_q        <= line_cnt_d;
            lines_per_frame_q <= lines_per_frame_d;
            frame_done_q      <= frame_done_d;
            line_len_err_q    <= line_len_err_d;
        end
    end

    assign lines_per_frame_o = lines_per_frame_q;
    assign frame_done_o      = frame_done_q;
    assign line_len_err_o    = line_len_err_q;
endmodule

// File: tb/tb_adaptive_sof_restorer.sv
// Self-checking bench for adaptive_sof_restorer in an 8-pixel-wide configuration.
module tb_adaptive_sof_restorer;
    localparam int RES_X = 8;
    localparam int RES_Y = 16;
    localparam int LCW   = $clog2(RES_Y + 1);

    logic           clk   = 1'b0;
    logic           rst_i = 1'b1;
    logic           eof_i = 1'b0;
    logic [LCW-1:0] lines_per_frame_o;
    logic           frame_done_o, line_len_err_o;

    axi4_stream_if #(.DATA_W(16)) vin ();
    axi4_stream_if #(.DATA_W(16)) vout ();

    adaptive_sof_restorer #(.FRAME_RES_X(RES_X), .FRAME_RES_Y(RES_Y), .PX_WIDTH(10)) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .video_i           (vin),
        .eof_i             (eof_i),
        .video_o           (vout),
        .lines_per_frame_o (lines_per_frame_o),
        .frame_done_o      (frame_done_o),
        .line_len_err_o    (line_len_err_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int rdy_pct = 100;
    int ncyc = 0;
    int stab_err = 0;
    logic [23:0] exp_q[$], act_q[$];
    int exp_done[$], act_done[$], exp_err[$], act_err[$];
    logic [LCW-1:0] exp_lpf = '0;

    // payload layout: [23:8] tdata, [7:6] tstrb, [5:4] tkeep, [3] tlast, [2] tuser, [1] tid, [0] tdest
    function automatic logic [23:0] out_pay();
        return {vout.tdata, vout.tstrb, vout.tkeep, vout.tlast, vout.tuser, vout.tid, vout.tdest};
    endfunction

    initial begin : rdy_driver
        vout.tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            vout.tready = ($urandom_range(99) < rdy_pct);
        end
    end

    // Reference model: frames start being forwarded after the first EOF seen since reset.
    initial begin : monitor
        bit          hold, m_sync, m_first;
        logic [23:0] held;
        int          m_px, m_lines;
        hold = 1'b0; held = '0; m_sync = 1'b0; m_first = 1'b0; m_px = 0; m_lines = 0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (frame_done_o === 1'b1) act_done.push_back(ncyc);
            if (line_len_err_o === 1'b1) act_err.push_back(ncyc);
            if (hold && (vout.tvalid !== 1'b1 || out_pay() !== held)) stab_err++;
            hold = (vout.tvalid === 1'b1) && (vout.tready !== 1'b1) && (rst_i !== 1'b1);
            held = out_pay();
            if (vout.tvalid === 1'b1 && vout.tready === 1'b1) act_q.push_back(out_pay());
            if (rst_i === 1'b1) begin
                m_sync = 1'b0; m_first = 1'b0; m_px = 0; m_lines = 0; exp_lpf = '0;
            end else if (vin.tvalid === 1'b1 && vin.tready === 1'b1) begin
                if (m_sync) begin
                    exp_q.push_back({vin.tdata, vin.tstrb, vin.tkeep, vin.tlast, m_first, vin.tid, vin.tdest});
                    m_first = 1'b0;
                end
                if (vin.tlast === 1'b1) begin
                    if (m_px + 1 != RES_X) exp_err.push_back(ncyc + 1);
                    m_px = 0;
                    if (eof_i === 1'b1) begin
                        exp_done.push_back(ncyc + 1);
                        if (m_sync) exp_lpf = LCW'((m_lines + 1 > RES_Y) ? RES_Y : m_lines + 1);
                        m_lines = 0; m_sync = 1'b1; m_first = 1'b1;
                    end else if (m_sync) begin
                        m_lines = (m_lines + 1 > RES_Y) ? RES_Y : m_lines + 1;
                    end
                end else begin
                    m_px = (m_px < 15) ? m_px + 1 : 15;
                end
            end
        end
    end

    task automatic clear_queues();
        exp_q.delete(); act_q.delete(); exp_done.delete(); act_done.delete();
        exp_err.delete(); act_err.delete();
    endtask

    task automatic idle(input int n);
        vin.tvalid = 1'b0; eof_i = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_beat(input bit last, input bit eof, input int gap_pct);
        bit acc;
        int waited;
        while (gap_pct > 0 && $urandom_range(99) < gap_pct) idle(1);
        vin.tvalid = 1'b1; vin.tdata = 16'($urandom); vin.tstrb = 2'($urandom);
        vin.tkeep = 2'($urandom); vin.tid = 1'($urandom); vin.tdest = 1'($urandom);
        vin.tuser = 1'($urandom); vin.tlast = last; eof_i = eof;
        waited = 0;
        forever begin
            @(negedge clk); acc = (vin.tready === 1'b1);
            @(posedge clk); #1;
            if (acc) break;
            waited++;
            if (waited > 200) begin
                n_cmp++; n_err++;
                $display("FAIL accept_timeout: beat still pending after %0d cycles, required accept", waited);
                break;
            end
        end
    endtask

    task automatic send_line(input int len, input bit eof, input int gap_pct, input int eof_mid);
        for (int i = 0; i < len; i++)
            send_beat(i == len - 1, (i == len - 1) ? eof : (i == eof_mid), gap_pct);
    endtask

    task automatic test_reset();
        idle(3);
        n_cmp++; if (vout.tvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid: got %b want 0", vout.tvalid); end
        n_cmp++; if (lines_per_frame_o !== '0) begin n_err++; $display("FAIL rst_lpf: got %0d want 0", lines_per_frame_o); end
        n_cmp++; if (frame_done_o !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", frame_done_o); end
        n_cmp++; if (line_len_err_o !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", line_len_err_o); end
        n_cmp++; if (vin.tready !== 1'b1) begin n_err++; $display("FAIL rst_tready: got %b want 1", vin.tready); end
    endtask

    task automatic test_sync_drop();
        int nu;
        rdy_pct = 100; clear_queues();
        for (int i = 0; i < 3; i++) send_beat(1'b0, 1'b0, 0);
        rst_i = 1'b0;
        send_line(5, 1'b0, 0, -1);
        send_line(8, 1'b0, 0, -1); send_line(8, 1'b0, 0, -1); send_line(8, 1'b1, 0, -1);
        for (int l = 0; l < 4; l++) send_line(8, l == 3, 0, -1);
        idle(20);
        n_cmp++; if (act_q.size() !== 32) begin n_err++; $display("FAIL sync_count: got %0d want 32", act_q.size()); end
        n_cmp++; if (act_q.size() !== exp_q.size()) begin n_err++; $display("FAIL sync_model_count: got %0d want %0d", act_q.size(), exp_q.size()); end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (act_q[i] !== exp_q[i]) begin n_err++; $display("FAIL sync_beat[%0d]: got %h want %h", i, act_q[i], exp_q[i]); end
        end
        nu = 0; foreach (act_q[i]) nu += int'(act_q[i][2]);
        n_cmp++; if (nu !== 1) begin n_err++; $display("FAIL sync_tuser_count: got %0d want 1", nu); end
        if (act_q.size() > 0) begin
            n_cmp++; if (act_q[0][2] !== 1'b1) begin n_err++; $display("FAIL sync_first_tuser: got %b want 1", act_q[0][2]); end
        end
        n_cmp++; if (lines_per_frame_o !== LCW'(4)) begin n_err++; $display("FAIL sync_lpf: got %0d want 4", lines_per_frame_o); end
        n_cmp++; if (act_done.size() !== 2) begin n_err++; $display("FAIL sync_done_count: got %0d want 2", act_done.size()); end
        for (int i = 0; i < act_done.size() && i < exp_done.size(); i++) begin
            n_cmp++; if (act_done[i] !== exp_done[i]) begin n_err++; $display("FAIL sync_done_cyc[%0d]: got %0d want %0d", i, act_done[i], exp_done[i]); end
        end
        n_cmp++; if (act_err.size() !== 1) begin n_err++; $display("FAIL sync_err_count: got %0d want 1", act_err.size()); end
        if (act_err.size() > 0 && exp_err.size() > 0) begin
            n_cmp++; if (act_err[0] !== exp_err[0]) begin n_err++; $display("FAIL sync_err_cyc: got %0d want %0d", act_err[0], exp_err[0]); end
        end
    endtask

    task automatic test_backpressure();
        int nu;
        rdy_pct = 50; clear_queues(); stab_err = 0;
        for (int f = 0; f < 3; f++)
            for (int l = 0; l < 4; l++) send_line(8, l == 3, 30, -1);
        idle(40);
        rdy_pct = 100; idle(4);
        n_cmp++; if (act_q.size() !== 96) begin n_err++; $display("FAIL bp_count: got %0d want 96", act_q.size()); end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (act_q[i] !== exp_q[i]) begin n_err++; $display("FAIL bp_beat[%0d]: got %h want %h", i, act_q[i], exp_q[i]); end
        end
        nu = 0; foreach (act_q[i]) nu += int'(act_q[i][2]);
        n_cmp++; if (nu !== 3) begin n_err++; $display("FAIL bp_tuser_count: got %0d want 3", nu); end
        n_cmp++; if (act_done.size() !== 3) begin n_err++; $display("FAIL bp_done_count: got %0d want 3", act_done.size()); end
        for (int i = 0; i < act_done.size() && i < exp_done.size(); i++) begin
            n_cmp++; if (act_done[i] !== exp_done[i]) begin n_err++; $display("FAIL bp_done_cyc[%0d]: got %0d want %0d", i, act_done[i], exp_done[i]); end
        end
        n_cmp++; if (act_err.size() !== 0) begin n_err++; $display("FAIL bp_err_count: got %0d want 0", act_err.size()); end
        n_cmp++; if (stab_err !== 0) begin n_err++; $display("FAIL bp_stable: got %0d changes while stalled, want 0", stab_err); end
        n_cmp++; if (lines_per_frame_o !== LCW'(4)) begin n_err++; $display("FAIL bp_lpf: got %0d want 4", lines_per_frame_o); end
    endtask

    task automatic test_line_len();
        clear_queues();
        send_line(8, 1'b0, 0, -1); send_line(7, 1'b0, 0, -1);
        send_line(8, 1'b0, 0, -1); send_line(8, 1'b1, 0, -1);
        idle(10);
        n_cmp++; if (act_err.size() !== 1) begin n_err++; $display("FAIL len_err_count: got %0d want 1", act_err.size()); end
        if (act_err.size() > 0 && exp_err.size() > 0) begin
            n_cmp++; if (act_err[0] !== exp_err[0]) begin n_err++; $display("FAIL len_err_cyc: got %0d want %0d", act_err[0], exp_err[0]); end
        end
        n_cmp++; if (act_q.size() !== 31) begin n_err++; $display("FAIL len_count: got %0d want 31", act_q.size()); end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (act_q[i] !== exp_q[i]) begin n_err++; $display("FAIL len_beat[%0d]: got %h want %h", i, act_q[i], exp_q[i]); end
        end
        n_cmp++; if (lines_per_frame_o !== LCW'(4)) begin n_err++; $display("FAIL len_lpf: got %0d want 4", lines_per_frame_o); end
    endtask

    task automatic test_eof_mid();
        int nu;
        clear_queues();
        send_line(8, 1'b0, 0, 3); send_line(8, 1'b1, 0, -1);
        idle(10);
        n_cmp++; if (act_q.size() !== 16) begin n_err++; $display("FAIL eofmid_count: got %0d want 16", act_q.size()); end
        if (act_q.size() > 4) begin
            n_cmp++; if (act_q[4][2] !== 1'b0) begin n_err++; $display("FAIL eofmid_next_tuser: got %b want 0", act_q[4][2]); end
        end
        nu = 0; foreach (act_q[i]) nu += int'(act_q[i][2]);
        n_cmp++; if (nu !== 1) begin n_err++; $display("FAIL eofmid_tuser_count: got %0d want 1", nu); end
        n_cmp++; if (act_done.size() !== 1) begin n_err++; $display("FAIL eofmid_done_count: got %0d want 1", act_done.size()); end
        n_cmp++; if (lines_per_frame_o !== LCW'(2)) begin n_err++; $display("FAIL eofmid_lpf: got %0d want 2", lines_per_frame_o); end
    endtask

    task automatic test_one_line();
        int nu;
        clear_queues();
        for (int f = 0; f < 3; f++) send_line(8, 1'b1, 0, -1);
        idle(10);
        n_cmp++; if (act_q.size() !== 24) begin n_err++; $display("FAIL one_count: got %0d want 24", act_q.size()); end
        for (int f = 0; f < 3 && 8 * f < act_q.size(); f++) begin
            n_cmp++; if (act_q[8*f][2] !== 1'b1) begin n_err++; $display("FAIL one_tuser[%0d]: got %b want 1", f, act_q[8*f][2]); end
        end
        nu = 0; foreach (act_q[i]) nu += int'(act_q[i][2]);
        n_cmp++; if (nu !== 3) begin n_err++; $display("FAIL one_tuser_count: got %0d want 3", nu); end
        n_cmp++; if (act_done.size() !== 3) begin n_err++; $display("FAIL one_done_count: got %0d want 3", act_done.size()); end
        n_cmp++; if (lines_per_frame_o !== LCW'(1)) begin n_err++; $display("FAIL one_lpf: got %0d want 1", lines_per_frame_o); end
    endtask

    task automatic test_reset_backpressure();
        rdy_pct = 0; idle(2);
        send_beat(1'b0, 1'b0, 0); send_beat(1'b0, 1'b0, 0);
        idle(3);
        n_cmp++; if (vout.tvalid !== 1'b1) begin n_err++; $display("FAIL rbp_held_valid: got %b want 1", vout.tvalid); end
        rst_i = 1'b1; @(posedge clk); #1; rst_i = 1'b0;
        n_cmp++; if (vout.tvalid !== 1'b0) begin n_err++; $display("FAIL rbp_tvalid: got %b want 0", vout.tvalid); end
        n_cmp++; if (lines_per_frame_o !== '0) begin n_err++; $display("FAIL rbp_lpf_rst: got %0d want 0", lines_per_frame_o); end
        n_cmp++; if (frame_done_o !== 1'b0) begin n_err++; $display("FAIL rbp_done: got %b want 0", frame_done_o); end
        n_cmp++; if (line_len_err_o !== 1'b0) begin n_err++; $display("FAIL rbp_err: got %b want 0", line_len_err_o); end
        n_cmp++; if (vin.tready !== 1'b1) begin n_err++; $display("FAIL rbp_tready: got %b want 1", vin.tready); end
        rdy_pct = 100; idle(2); clear_queues();
        send_line(8, 1'b0, 0, -1); send_line(8, 1'b1, 0, -1);
        send_line(8, 1'b0, 0, -1); send_line(8, 1'b1, 0, -1);
        idle(10);
        n_cmp++; if (act_q.size() !== 16) begin n_err++; $display("FAIL rbp_count: got %0d want 16", act_q.size()); end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (act_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rbp_beat[%0d]: got %h want %h", i, act_q[i], exp_q[i]); end
        end
        if (act_q.size() > 0) begin
            n_cmp++; if (act_q[0][2] !== 1'b1) begin n_err++; $display("FAIL rbp_first_tuser: got %b want 1", act_q[0][2]); end
        end
        n_cmp++; if (act_done.size() !== 2) begin n_err++; $display("FAIL rbp_done_count: got %0d want 2", act_done.size()); end
        n_cmp++; if (act_err.size() !== 0) begin n_err++; $display("FAIL rbp_err_count: got %0d want 0", act_err.size()); end
        n_cmp++; if (lines_per_frame_o !== LCW'(2)) begin n_err++; $display("FAIL rbp_lpf: got %0d want 2", lines_per_frame_o); end
        n_cmp++; if (lines_per_frame_o !== exp_lpf) begin n_err++; $display("FAIL rbp_lpf_model: got %0d want %0d", lines_per_frame_o, exp_lpf); end
    endtask

    initial begin : main
        vin.tvalid = 1'b0; vin.tdata = '0; vin.tstrb = '0; vin.tkeep = '0;
        vin.tlast = 1'b0; vin.tuser = 1'b0; vin.tid = 1'b0; vin.tdest = 1'b0;
        test_reset();
        test_sync_drop();
        test_backpressure();
        test_line_len();
        test_eof_mid();
        test_one_line();
        test_reset_backpressure();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
